alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential initiator for the combinational ALU. It accepts tagged commands over a valid/ready handshake and registers the opcode and operands onto the ALU input bus. It holds that bus stable for a fixed settle window, then captures the ALU result and overflow flag. The captured result goes into a 2-entry response FIFO, which is returned over a second valid/ready handshake. It sits between the instruction sequencer and the ALU, and is the only driver of the ALU inputs.

## Interface
- SETTLE_CYCLES, 1: cycles the ALU inputs are held before capture; legal range 1..15.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at the clk edge.
- cmd_op  in  3  ALU opcode: 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOT; 000 and 111 are illegal.
- cmd_a  in  32  first operand.
- cmd_b  in  4  second operand.
- cmd_tag  in  4  echoed unchanged on the response.
- alu_opcode  out  3  to the ALU.
- alu_operand1  out  33  to the ALU; equals {1'b0, cmd_a}.
- alu_operand2  out  4  to the ALU.
- alu_res_out  in  32  from the ALU.
- alu_overflow  in  1  from the ALU.
- rsp_valid  out  1  FIFO head is valid.
- rsp_ready  in  1  head is popped when rsp_valid && rsp_ready at the clk edge.
- rsp_data  out  32  result.
- rsp_ovf  out  1  captured alu_overflow.
- rsp_zero  out  1  1 when rsp_data == 0.
- rsp_err  out  1  1 for an illegal opcode.
- rsp_tag  out  4  tag of the command.

## Operation
- FSM states:
  - IDLE: cmd_ready = (fifo_count < 2).
    - On accept with a legal opcode: latch op, a, b and tag; load cnt = SETTLE_CYCLES-1; go to SETTLE.
    - On accept with opcode 000 or 111: latch tag; go to ERR.
  - SETTLE: cmd_ready = 0; ALU bus driven from the latched values.
    - While cnt != 0: decrement cnt.
    - When cnt == 0: push {alu_res_out, alu_overflow, zero, err=0, tag} into the FIFO at that edge; go to IDLE.
  - ERR: cmd_ready = 0; ALU bus stays idle. At the next edge, push {data=0, ovf=0, zero=1, err=1, tag}; go to IDLE.
- Idle ALU bus: alu_opcode = 000, alu_operand1 = 0, alu_operand2 = 0 in IDLE and ERR. Opcode 000 makes the ALU output 0, so no stray results are produced.
- zero flag: computed from alu_res_out at capture time, not at pop time.
- FIFO space: a command is accepted only when the FIFO has a free slot. The FIFO can only drain while a command is in flight, so a push never hits a full FIFO and no overflow logic is needed.
- FIFO behaviour:
  - 2 entries, first in, first out.
  - rsp_* outputs show the head combinationally from storage. They are registered values with no path from the ALU.
  - Push and pop on the same edge: count is unchanged and ordering is preserved.
  - Read and write pointers are 1 bit each and wrap from 1 to 0.
- Width rules:
  - The ALU produces 33 bits internally and only bits 31:0 are returned.
  - alu_operand1 bit 32 is always 0.
  - cmd_b is zero-extended by the ALU.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert use):
  - state = IDLE, fifo_count = 0, pointers = 0, cnt = 0.
  - Latched op/a/b/tag = 0.
  - Outputs: cmd_ready = 1 on the first cycle after release; rsp_valid = 0; rsp_data = 0; rsp_ovf = 0; rsp_zero = 0; rsp_err = 0; rsp_tag = 0; ALU bus all 0.
- Reset asserted mid-SETTLE or mid-ERR: the in-flight command is dropped and produces no response. Queued responses are discarded.
- Legal-command latency: accept at edge E0 puts the ALU bus valid from E0 onward. The push happens at edge E0+SETTLE_CYCLES, and rsp_valid is high in the cycle after that edge when the FIFO was empty.
- Illegal-command latency: push at E0+1.
- Throughput: a legal command issues at most once every SETTLE_CYCLES+1 cycles. The accept cycle back in IDLE follows the push edge.
- cmd_ready is held low in IDLE whenever fifo_count == 2. It rises in the cycle after the pop edge.
- rsp_valid stays high and rsp_* stay stable until popped.

## Test plan
- ADD, SETTLE_CYCLES=1: op=001, a=5, b=3, tag=2; rsp_ready=1 → rsp_valid one cycle after the accept edge; data=8, zero=0, ovf=alu_overflow, err=0, tag=2.
- SUB zero result: op=010, a=3, b=3 → data=0, zero=1. Also NOT with a=0xFFFFFFFF → data=0, zero=1.
- Backpressure: rsp_ready=0; issue ADD tags 1, 2, 3 back to back → tags 1 and 2 accepted, cmd_ready=0 holds tag 3. Raise rsp_ready → pops come out in tag order 1, 2, 3, and tag 3 is accepted the cycle after the first pop.
- Illegal opcode: op=111, tag=9 → alu_opcode stays 000; response at E0+1 with err=1, data=0, zero=1, tag=9.
- SETTLE_CYCLES=4: during the window the ALU bus is held constant and cmd_ready=0. The push is at E0+4, with result equal to the ALU output sampled at that edge.
- Reset mid-SETTLE: assert rst_n=0 two cycles after accept → all outputs go to their reset values immediately; no response appears after release; cmd_ready=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: registers a command onto the ALU bus,
// holds it for SETTLE_CYCLES, captures the result into a 2-entry response FIFO.
module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [3:0]  cmd_b,
  input  logic [3:0]  cmd_tag,
  output logic [2:0]  alu_opcode,
  output logic [32:0] alu_operand1,
  output logic [3:0]  alu_operand2,
  input  logic [31:0] alu_res_out,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_ovf,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [3:0]  rsp_tag
);

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic        zero;
    logic        err;
    logic [3:0]  tag;
  } rsp_t;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] ERR    = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [3:0]  b_q;
  logic [3:0]  tag_q;

  rsp_t        fifo [2];
  logic        wptr, rptr;
  logic [1:0]  count;

  logic accept, legal, push, pop;
  rsp_t push_ent;
  rsp_t head;

  assign cmd_ready = (state == IDLE) && (count != 2'd2);
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = (cmd_op != 3'b000) && (cmd_op != 3'b111);
  assign push      = ((state == SETTLE) && (cnt == 4'd0)) || (state == ERR);
  assign pop       = rsp_valid && rsp_ready;

  // Bus is zero outside SETTLE so the ALU sees opcode 000 and produces nothing.
  assign alu_opcode   = (state == SETTLE) ? op_q : 3'b000;
  assign alu_operand1 = (state == SETTLE) ? {1'b0, a_q} : 33'd0;
  assign alu_operand2 = (state == SETTLE) ? b_q : 4'd0;

  always_comb begin
    push_ent     = '0;
    push_ent.tag = tag_q;
    if (state == ERR) begin
      push_ent.zero = 1'b1;
      push_ent.err  = 1'b1;
    end else begin
      push_ent.data = alu_res_out;
      push_ent.ovf  = alu_overflow;
      push_ent.zero = (alu_res_out == 32'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 4'd0;
      tag_q <= 4'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          tag_q <= cmd_tag;
          if (legal) begin
            op_q  <= cmd_op;
            a_q   <= cmd_a;
            b_q   <= cmd_b;
            cnt   <= CNT_INIT;
            state <= SETTLE;
          end else begin
            state <= ERR;
          end
        end
        SETTLE: if (cnt == 4'd0) state <= IDLE;
                else             cnt   <= cnt - 4'd1;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // No full check on push: a command is only accepted with a free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        fifo[wptr] <= push_ent;
        wptr       <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head      = fifo[rptr];
  assign rsp_valid = (count != 2'd0);
  assign rsp_data  = head.data;
  assign rsp_ovf   = head.ovf;
  assign rsp_zero  = head.zero;
  assign rsp_err   = head.err;
  assign rsp_tag   = head.tag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl at SETTLE_CYCLES 1 and 4, checked against a
// cycle-level transaction model (expected-response queue with push-edge stamps).
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit done [2];

  typedef struct {
    logic [31:0] d;
    logic        ovf;
    logic        z;
    logic        err;
    logic [3:0]  tag;
    int          pe;
  } exp_t;

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask

  // Reference ALU: {overflow/borrow, result}
  function automatic logic [32:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [3:0] b);
    logic [32:0] x;
    x = {1'b0, a};
    case (op)
      3'd1:    return x + 33'(b);
      3'd2:    return x - 33'(b);
      3'd3:    return {1'b0, a & 32'(b)};
      3'd4:    return {1'b0, a | 32'(b)};
      3'd5:    return {1'b0, a ^ 32'(b)};
      3'd6:    return {1'b0, ~a};
      default: return 33'd0;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int SC = (g == 0) ? 1 : 4;

    logic        rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [2:0]  cmd_op, alu_opcode;
    logic [31:0] cmd_a, alu_res_out, rsp_data;
    logic [3:0]  cmd_b, cmd_tag, alu_operand2, rsp_tag;
    logic [32:0] alu_operand1;
    logic        alu_overflow, rsp_ovf, rsp_zero, rsp_err;

    assign {alu_overflow, alu_res_out} = alu_f(alu_opcode, alu_operand1[31:0], alu_operand2);

    alu_issue_ctrl #(.SETTLE_CYCLES(SC)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
      .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
      .alu_res_out(alu_res_out), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
    );

    string       pfx;
    int          n = 0;
    int          busy_end = 0;
    exp_t        q[$];
    bit          cur_legal = 0;
    logic [39:0] cur_bus = '0;
    bit          last_acc = 0;

    task automatic cmp();
      bit v;
      chk({pfx, ".cmd_ready"}, cmd_ready, (n >= busy_end) && (q.size() < 2));
      v = (q.size() > 0) && (q[0].pe <= n);
      chk({pfx, ".rsp_valid"}, rsp_valid, v);
      if (v) begin
        chk({pfx, ".rsp_data"}, rsp_data, q[0].d);
        chk({pfx, ".rsp_ovf"},  rsp_ovf,  q[0].ovf);
        chk({pfx, ".rsp_zero"}, rsp_zero, q[0].z);
        chk({pfx, ".rsp_err"},  rsp_err,  q[0].err);
        chk({pfx, ".rsp_tag"},  rsp_tag,  q[0].tag);
      end
      chk({pfx, ".alu_bus"}, {alu_opcode, alu_operand1, alu_operand2},
          (cur_legal && n < busy_end) ? cur_bus : 40'd0);
    endtask

    task automatic step();
      bit acc, pop, legal;
      logic [32:0] r;
      exp_t e;
      acc = cmd_valid && (n >= busy_end) && (q.size() < 2);
      pop = rsp_ready && (q.size() > 0) && (q[0].pe <= n);
      @(posedge clk);
      n++;
      if (pop) void'(q.pop_front());
      if (acc) begin
        legal = (cmd_op != 3'd0) && (cmd_op != 3'd7);
        r = alu_f(cmd_op, cmd_a, cmd_b);
        e.d   = legal ? r[31:0] : 32'd0;
        e.ovf = legal ? r[32] : 1'b0;
        e.z   = legal ? (r[31:0] == 32'd0) : 1'b1;
        e.err = !legal;
        e.tag = cmd_tag;
        e.pe  = n + (legal ? SC : 1);
        q.push_back(e);
        busy_end  = e.pe;
        cur_legal = legal;
        cur_bus   = {cmd_op, 1'b0, cmd_a, cmd_b};
      end
      last_acc = acc;
      @(negedge clk);
      cmp();
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [3:0] b, input logic [3:0] tag);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
      for (int i = 0; i < 40; i++) begin
        step();
        if (last_acc) break;
      end
      if (!last_acc) chk({pfx, ".accept_timeout"}, 1'b0, 1'b1);
      cmd_valid = 1'b0;
    endtask

    task automatic drain();
      rsp_ready = 1'b1;
      repeat (SC + 4) step();
    endtask

    initial begin
      pfx = (g == 0) ? "s1" : "s4";
      rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
      repeat (2) @(negedge clk);
      chk({pfx, ".rst_rsp"}, {rsp_valid, rsp_data, rsp_ovf, rsp_zero, rsp_err, rsp_tag}, 40'd0);
      chk({pfx, ".rst_bus"}, {alu_opcode, alu_operand1, alu_operand2}, 40'd0);
      rst_n = 1'b1;
      cmp();

      rsp_ready = 1'b1;
      issue(3'd1, 32'd5, 4'd3, 4'd2);          // ADD -> 8
      drain();
      issue(3'd2, 32'd3, 4'd3, 4'd4);          // SUB -> 0
      drain();
      issue(3'd6, 32'hFFFF_FFFF, 4'd0, 4'd5);  // NOT -> 0
      drain();
      issue(3'd1, 32'hFFFF_FFFF, 4'd1, 4'd6);  // ADD carry out
      drain();
      issue(3'd7, 32'd1234, 4'd7, 4'd9);       // illegal
      drain();
      issue(3'd0, 32'd1, 4'd1, 4'd10);         // illegal
      drain();

      rsp_ready = 1'b0;
      issue(3'd1, 32'd10, 4'd1, 4'd1);
      issue(3'd1, 32'd20, 4'd2, 4'd2);
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 32'd30; cmd_b = 4'd3; cmd_tag = 4'd3;
      repeat (SC + 5) step();
      chk({pfx, ".tag3_held"}, last_acc, 1'b0);
      rsp_ready = 1'b1;
      issue(3'd1, 32'd30, 4'd3, 4'd3);
      drain();

      for (int i = 0; i < 300; i++) begin
        cmd_valid = $urandom_range(0, 1);
        cmd_op    = 3'($urandom);
        case ($urandom_range(0, 3))
          0:       cmd_a = 32'd0;
          1:       cmd_a = 32'hFFFF_FFFF;
          default: cmd_a = $urandom;
        endcase
        cmd_b     = 4'($urandom);
        cmd_tag   = 4'($urandom);
        rsp_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      cmd_valid = 1'b0;
      drain();

      // Reset two cycles after accept; queued and in-flight work must vanish.
      rsp_ready = 1'b0;
      issue(3'd5, 32'hA5A5_0F0F, 4'hC, 4'd7);
      step();
      #2 rst_n = 1'b0;
      #1;
      chk({pfx, ".rst_mid_rsp"}, {rsp_valid, rsp_data, rsp_ovf, rsp_zero, rsp_err, rsp_tag}, 40'd0);
      chk({pfx, ".rst_mid_bus"}, {alu_opcode, alu_operand1, alu_operand2}, 40'd0);
      q.delete();
      busy_end  = n;
      cur_legal = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cmp();
      rsp_ready = 1'b1;
      repeat (SC + 4) step();
      done[g] = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(done[0] && done[1]) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(done[0] && done[1])) chk("timeout", 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
